// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the convolution engine and its
// downstream ReLU/max-pool stage.
package cnn_pkg;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_MAC,
        CONV_DONE
    } conv_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISHED
    } pool_state_t;

    // Static-only class so the helpers can be specialised to the pixel width.
    virtual class cnn_fn #(parameter int W = 32);
        static function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] v);
            return v[W-1] ? '0 : v;
        endfunction

        static function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                             input logic signed [W-1:0] b);
            return (a > b) ? a : b;
        endfunction
    endclass

endpackage

// File: rtl/relu_maxpool_if.sv
// Pixel stream into and pooled stream out of the ReLU/max-pool stage.
interface relu_maxpool_if #(parameter int ACC_WIDTH = 32);
    logic                        start;
    logic signed [ACC_WIDTH-1:0] in_pixel;
    logic                        in_valid;
    logic signed [ACC_WIDTH-1:0] out_pixel;
    logic                        out_valid;
    logic                        done;

    modport master (output start, in_pixel, in_valid,
                    input  out_pixel, out_valid, done);
    modport slave  (input  start, in_pixel, in_valid,
                    output out_pixel, out_valid, done);
endinterface

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2 stride-2 max-pool; one row of partial
// maxima is kept so no frame storage is needed.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int IN_H      = 4,
    parameter int IN_W      = 4
) (
    input  logic           clk,
    input  logic           rst,
    relu_maxpool_if.slave  bus
);

    localparam int POOL_W = IN_W / 2;
    localparam int RW     = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int IW     = (POOL_W > 1) ? $clog2(POOL_W) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);

    pool_state_t                 state_reg;
    logic [RW-1:0]               row_reg;
    logic [CW-1:0]               col_reg;
    logic signed [ACC_WIDTH-1:0] hold_reg;
    logic signed [ACC_WIDTH-1:0] out_pixel_reg;
    logic                        out_valid_reg;
    logic                        done_reg;
    logic signed [ACC_WIDTH-1:0] linebuf [POOL_W];

    logic [IW-1:0]               pidx;
    logic signed [ACC_WIDTH-1:0] relu_px;
    logic signed [ACC_WIDTH-1:0] pair_max;
    logic signed [ACC_WIDTH-1:0] win_max;
    logic                        accept;

    assign accept = (state_reg == RUN) && bus.in_valid;
    assign pidx   = IW'(col_reg >> 1);

    always_comb begin
        relu_px  = cnn_fn#(ACC_WIDTH)::relu(bus.in_pixel);
        pair_max = cnn_fn#(ACC_WIDTH)::smax(hold_reg, relu_px);
        win_max  = cnn_fn#(ACC_WIDTH)::smax(linebuf[pidx], pair_max);
    end

    // Even rows leave their horizontal pair maxima here for the odd row below.
    always_ff @(posedge clk) begin
        if (accept && col_reg[0] && !row_reg[0]) begin
            linebuf[pidx] <= pair_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            hold_reg      <= '0;
            out_pixel_reg <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE, FINISHED: begin
                    if (bus.start) begin
                        state_reg <= RUN;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        done_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        if (!col_reg[0]) begin
                            hold_reg <= relu_px;
                        end else if (row_reg[0]) begin
                            out_pixel_reg <= win_max;
                            out_valid_reg <= 1'b1;
                        end
                        if (col_reg == COL_LAST) begin
                            col_reg <= '0;
                            if (row_reg == ROW_LAST) begin
                                row_reg   <= '0;
                                state_reg <= FINISHED;
                                done_reg  <= 1'b1;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.out_pixel = out_pixel_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: a 4x4 instance and a 3x3 instance checked
// against a plain-arithmetic pooling model.
module tb_relu_maxpool;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    relu_maxpool_if #(.ACC_WIDTH(32)) ifa ();
    relu_maxpool_if #(.ACC_WIDTH(32)) ifb ();

    relu_maxpool #(.ACC_WIDTH(32), .IN_H(4), .IN_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    relu_maxpool #(.ACC_WIDTH(32), .IN_H(3), .IN_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    int exp_b[$];
    bit done_on_last_a = 1'b1;
    bit done_on_last_b = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: every complete 2x2 window, max over the clamped pixels.
    function automatic void pool_model(input int h, input int w, input int px[$], output int res[$]);
        res = {};
        for (int pr = 0; pr < h / 2; pr++) begin
            for (int pc = 0; pc < w / 2; pc++) begin
                int m;
                m = 0;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        int v;
                        v = px[(2 * pr + dr) * w + 2 * pc + dc];
                        if (v > m) m = v;
                    end
                end
                res.push_back(m);
            end
        end
    endfunction

    always @(negedge clk) begin : cmp_a
        int e;
        if (!rst && ifa.out_valid) begin
            $display("dut_a pulse: out_pixel=%0d done=%0d", ifa.out_pixel, ifa.done);
            if (exp_a.size() == 0) begin
                chk("extra_pulse_a", 1, 0);
            end else begin
                e = exp_a.pop_front();
                chk("pixel_a", ifa.out_pixel, e);
                chk("done_with_pulse_a", ifa.done, (exp_a.size() == 0 && done_on_last_a) ? 1 : 0);
            end
        end
    end

    always @(negedge clk) begin : cmp_b
        int e;
        if (!rst && ifb.out_valid) begin
            $display("dut_b pulse: out_pixel=%0d done=%0d", ifb.out_pixel, ifb.done);
            if (exp_b.size() == 0) begin
                chk("extra_pulse_b", 1, 0);
            end else begin
                e = exp_b.pop_front();
                chk("pixel_b", ifb.out_pixel, e);
                chk("done_with_pulse_b", ifb.done, (exp_b.size() == 0 && done_on_last_b) ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input int px[$], input int n, input int max_gap);
        tick();
        if (b) ifb.start = 1'b1; else ifa.start = 1'b1;
        tick();
        if (b) ifb.start = 1'b0; else ifa.start = 1'b0;
        chk(b ? "done_cleared_b" : "done_cleared_a", b ? ifb.done : ifa.done, 0);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) tick();
            if (b) begin
                ifb.in_pixel = px[i];
                ifb.in_valid = 1'b1;
            end else begin
                ifa.in_pixel = px[i];
                ifa.in_valid = 1'b1;
            end
            tick();
            ifa.in_valid = 1'b0;
            ifb.in_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input bit b, input int h, input int w, input int px[$], input int max_gap);
        int res[$];
        pool_model(h, w, px, res);
        if (b) begin
            done_on_last_b = (h % 2 == 0) && (w % 2 == 0);
            foreach (res[i]) exp_b.push_back(res[i]);
        end else begin
            done_on_last_a = (h % 2 == 0) && (w % 2 == 0);
            foreach (res[i]) exp_a.push_back(res[i]);
        end
        drive(b, px, h * w, max_gap);
        repeat (3) tick();
        chk(b ? "missing_pulses_b" : "missing_pulses_a", b ? exp_b.size() : exp_a.size(), 0);
        chk(b ? "done_held_b" : "done_held_a", b ? ifb.done : ifa.done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int px[$];
        int res[$];

        rst = 1'b1;
        ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_pixel = '0;
        ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_pixel = '0;
        repeat (3) tick();
        chk("reset_out_valid", ifa.out_valid, 0);
        chk("reset_out_pixel", ifa.out_pixel, 0);
        chk("reset_done", ifa.done, 0);
        rst = 1'b0;
        tick();

        // Model pinned against hand-worked windows.
        px = {};
        for (int i = 1; i <= 16; i++) px.push_back(i);
        pool_model(4, 4, px, res);
        chk("model_up_0", res[0], 6);
        chk("model_up_1", res[1], 8);
        chk("model_up_2", res[2], 14);
        chk("model_up_3", res[3], 16);

        // 1..16 continuous.
        run_frame(1'b0, 4, 4, px, 0);

        // All negative: clamps to zero.
        px = {};
        for (int i = 0; i < 16; i++) px.push_back(-3);
        pool_model(4, 4, px, res);
        chk("model_neg", res[2], 0);
        run_frame(1'b0, 4, 4, px, 0);

        // First window entirely negative.
        px = {};
        for (int i = 0; i < 16; i++) px.push_back(i + 1);
        px[0] = -5; px[1] = -3; px[4] = -7; px[5] = -1;
        pool_model(4, 4, px, res);
        chk("model_negwin_0", res[0], 0);
        chk("model_negwin_1", res[1], 8);
        run_frame(1'b0, 4, 4, px, 0);

        // 1..16 with random input gaps.
        px = {};
        for (int i = 1; i <= 16; i++) px.push_back(i);
        run_frame(1'b0, 4, 4, px, 3);

        // Abort after 6 pixels; (1,1) closes the first window before reset.
        done_on_last_a = 1'b0;
        exp_a.push_back(6);
        drive(1'b0, px, 6, 0);
        repeat (2) tick();
        chk("abort_pulse_seen", exp_a.size(), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", ifa.out_valid, 0);
        chk("abort_out_pixel", ifa.out_pixel, 0);
        chk("abort_done", ifa.done, 0);
        repeat (2) tick();
        chk("abort_idle_quiet", ifa.out_valid, 0);
        run_frame(1'b0, 4, 4, px, 0);

        // Restart from FINISHED with descending values.
        px = {};
        for (int i = 16; i >= 1; i--) px.push_back(i);
        pool_model(4, 4, px, res);
        chk("model_down_0", res[0], 16);
        chk("model_down_1", res[1], 14);
        chk("model_down_2", res[2], 8);
        chk("model_down_3", res[3], 6);
        run_frame(1'b0, 4, 4, px, 0);

        // 3x3: odd row/column dropped, a single window.
        px = {};
        for (int i = 1; i <= 9; i++) px.push_back(i);
        pool_model(3, 3, px, res);
        chk("model_3x3_count", res.size(), 1);
        chk("model_3x3_val", res[0], 5);
        run_frame(1'b1, 3, 3, px, 0);
        repeat (4) tick();
        chk("quiet_after_3x3", ifb.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
